// File: rtl/err_inject_sequencer_pkg.sv
// err_inject_sequencer_pkg: shared state encoding and default widths for the error-injection sequencer
package err_inject_sequencer_pkg;
    localparam int ERR_CTRL_W = 1;
    localparam int DLY_W_DEF  = 16;
    localparam int LEN_W_DEF  = 8;
    localparam int CNT_W_DEF  = 8;
    typedef enum logic [2:0] {IDLE, ARMED, DELAY, INJECT, GAP} state_t;
endpackage

// File: rtl/err_inject_sequencer_down_counter.sv
// err_inject_sequencer_down_counter: loadable down-counter that stops at zero and flags it
module err_inject_sequencer_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] cnt;
    // load wins over decrement; decrement halts at zero so the count never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= value;
        else if (en && cnt != '0) cnt <= cnt - W'(1);
    end
    assign zero = (cnt == '0);
endmodule

// File: rtl/err_inject_sequencer.sv
// err_inject_sequencer: timed burst generator driving the err_ctrl bus of the error splitter
module err_inject_sequencer
    import err_inject_sequencer_pkg::*;
#(
    parameter int CTRL_W = ERR_CTRL_W,
    parameter int DLY_W  = DLY_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DLY_W-1:0]  cfg_delay,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [DLY_W-1:0]  cfg_gap,
    input  logic [CNT_W-1:0]  cfg_repeat,
    input  logic [CTRL_W-1:0] cfg_mask,
    input  logic              start,
    input  logic              abort,
    output logic [CTRL_W-1:0] err_ctrl,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  inj_count
);
    state_t state, state_n;
    logic [DLY_W-1:0]  delay_r, gap_r, eff_delay;
    logic [LEN_W-1:0]  len_r, eff_len, len_sel;
    logic [CNT_W-1:0]  rep_r, rem, eff_rep, inj_base, inj_n;
    logic [CTRL_W-1:0] mask_r, eff_mask, err_n;
    logic hs, go, len_end, more, burst_start, dg_zero, len_zero, dg_load;
    logic busy_n, done_n, ready_n;

    // a config offered in the same cycle as start is the one that start uses
    assign hs        = cfg_valid && (state == IDLE || state == ARMED) && !abort;
    assign go        = start && state == ARMED && !abort;
    assign eff_delay = hs ? cfg_delay : delay_r;
    assign eff_len   = hs ? cfg_len : len_r;
    assign eff_rep   = hs ? cfg_repeat : rep_r;
    assign eff_mask  = hs ? cfg_mask : mask_r;
    assign len_end   = state == INJECT && len_zero;
    assign more      = rep_r == '0 || rem != CNT_W'(1);
    assign burst_start = state_n == INJECT && (state != INJECT || len_end);
    assign dg_load   = (go && eff_delay != '0) || (len_end && more && gap_r != '0);
    assign len_sel   = go ? eff_len : len_r;

    err_inject_sequencer_down_counter #(.W(DLY_W)) u_dg_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (dg_load),
        .en    (state == DELAY || state == GAP),
        .value (go ? eff_delay - DLY_W'(1) : gap_r - DLY_W'(1)),
        .zero  (dg_zero)
    );

    err_inject_sequencer_down_counter #(.W(LEN_W)) u_len_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (burst_start),
        .en    (state == INJECT),
        .value (len_sel == '0 ? '0 : len_sel - LEN_W'(1)),
        .zero  (len_zero)
    );

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            err_ctrl  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_ready <= 1'b1;
            inj_count <= '0;
        end else begin
            state     <= state_n;
            err_ctrl  <= err_n;
            busy      <= busy_n;
            done      <= done_n;
            cfg_ready <= ready_n;
            inj_count <= inj_n;
        end
    end

    // next-state decision; abort overrides every other input
    always_comb begin
        state_n = state;
        if (abort) state_n = IDLE;
        else begin
            case (state)
                IDLE:    state_n = hs ? ARMED : IDLE;
                ARMED:   state_n = go ? (eff_delay == '0 ? INJECT : DELAY) : ARMED;
                DELAY:   state_n = dg_zero ? INJECT : DELAY;
                INJECT:  state_n = !len_end ? INJECT : !more ? ARMED : gap_r != '0 ? GAP : INJECT;
                GAP:     state_n = dg_zero ? INJECT : GAP;
                default: state_n = IDLE;
            endcase
        end
    end

    // output values for the coming cycle, derived from the next state
    always_comb begin
        err_n    = state_n == INJECT ? eff_mask : '0;
        busy_n   = state_n == DELAY || state_n == INJECT || state_n == GAP;
        done_n   = len_end && !more && !abort;
        ready_n  = state_n == IDLE || state_n == ARMED;
        inj_base = hs ? '0 : inj_count;
        inj_n    = burst_start && inj_base != '1 ? inj_base + CNT_W'(1) : inj_base;
    end

    // latched profile and remaining-burst count; abort forgets the profile
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_r <= '0;
            len_r   <= '0;
            gap_r   <= '0;
            rep_r   <= '0;
            mask_r  <= '0;
            rem     <= '0;
        end else begin
            if (abort) begin
                delay_r <= '0;
                len_r   <= '0;
                gap_r   <= '0;
                rep_r   <= '0;
                mask_r  <= '0;
            end else if (hs) begin
                delay_r <= cfg_delay;
                len_r   <= cfg_len;
                gap_r   <= cfg_gap;
                rep_r   <= cfg_repeat;
                mask_r  <= cfg_mask;
            end
            if (go) rem <= eff_rep;
            else if (len_end && rep_r != '0) rem <= rem - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_err_inject_sequencer.sv
// tb_err_inject_sequencer: directed self-checking bench for the error-injection sequencer
module tb_err_inject_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_delay = '0;
    logic [7:0]  cfg_len = '0;
    logic [15:0] cfg_gap = '0;
    logic [7:0]  cfg_repeat = '0;
    logic [0:0]  cfg_mask = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [0:0]  err_ctrl;
    logic        busy;
    logic        done;
    logic [7:0]  inj_count;
    int compared = 0;
    int mismatched = 0;

    err_inject_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_delay  (cfg_delay),
        .cfg_len    (cfg_len),
        .cfg_gap    (cfg_gap),
        .cfg_repeat (cfg_repeat),
        .cfg_mask   (cfg_mask),
        .start      (start),
        .abort      (abort),
        .err_ctrl   (err_ctrl),
        .busy       (busy),
        .done       (done),
        .inj_count  (inj_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_cfg(input int d, input int l, input int g, input int r, input int m);
        cfg_delay  = 16'(d);
        cfg_len    = 8'(l);
        cfg_gap    = 16'(g);
        cfg_repeat = 8'(r);
        cfg_mask   = 1'(m);
        cfg_valid  = 1'b1;
        tick();
        cfg_valid  = 1'b0;
    endtask

    task automatic fire();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // power-on reset
        tick();
        tick();
        chk("rst_err", 32'(err_ctrl), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_inj", 32'(inj_count), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 32'(cfg_ready), 1);
        // single burst after a delay of 3
        load_cfg(3, 2, 0, 1, 1);
        chk("t2_ready_armed", 32'(cfg_ready), 1);
        fire();
        for (int i = 1; i <= 7; i++) begin
            chk($sformatf("t2_err_%0d", i), 32'(err_ctrl), (i == 4 || i == 5) ? 1 : 0);
            chk($sformatf("t2_done_%0d", i), 32'(done), i == 6 ? 1 : 0);
            chk($sformatf("t2_busy_%0d", i), 32'(busy), i <= 5 ? 1 : 0);
            if (i < 7) tick();
        end
        chk("t2_inj", 32'(inj_count), 1);
        chk("t2_ready", 32'(cfg_ready), 1);
        // three 1-cycle bursts separated by 2 idle cycles
        load_cfg(0, 1, 2, 3, 1);
        chk("t3_inj_clear", 32'(inj_count), 0);
        fire();
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("t3_err_%0d", i), 32'(err_ctrl), (i <= 7 && i % 3 == 1) ? 1 : 0);
            chk($sformatf("t3_done_%0d", i), 32'(done), i == 8 ? 1 : 0);
            if (i < 8) tick();
        end
        chk("t3_inj", 32'(inj_count), 3);
        // zero length with no gap: two bursts merge
        load_cfg(0, 0, 0, 2, 1);
        fire();
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("t4_err_%0d", i), 32'(err_ctrl), i <= 2 ? 1 : 0);
            chk($sformatf("t4_done_%0d", i), 32'(done), i == 3 ? 1 : 0);
            if (i == 2) chk("t4_inj_mid", 32'(inj_count), 2);
            if (i < 3) tick();
        end
        chk("t4_inj", 32'(inj_count), 2);
        // replay of the retained profile keeps counting
        fire();
        tick();
        tick();
        chk("t4_replay_done", 32'(done), 1);
        chk("t4_replay_inj", 32'(inj_count), 4);
        // continuous mode, aborted after 300 cycles
        load_cfg(0, 1, 1, 0, 1);
        fire();
        for (int i = 1; i <= 300; i++) begin
            if (i % 50 == 1 || i % 50 == 2) chk($sformatf("t5_err_%0d", i), 32'(err_ctrl), i % 2);
            if (i == 300) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        chk("t5_err", 32'(err_ctrl), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_ready", 32'(cfg_ready), 1);
        chk("t5_inj", 32'(inj_count), 150);
        fire();
        chk("t5_idle_start", 32'(busy), 0);
        // start together with abort in ARMED
        load_cfg(0, 2, 0, 1, 1);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t6_err", 32'(err_ctrl), 0);
        chk("t6_busy", 32'(busy), 0);
        fire();
        chk("t6_idle_err", 32'(err_ctrl), 0);
        chk("t6_idle_busy", 32'(busy), 0);
        // start pulses and config offers while busy are ignored
        load_cfg(2, 3, 0, 1, 1);
        fire();
        for (int i = 1; i <= 7; i++) begin
            chk($sformatf("t6_err_%0d", i), 32'(err_ctrl), (i >= 3 && i <= 5) ? 1 : 0);
            chk($sformatf("t6_done_%0d", i), 32'(done), i == 6 ? 1 : 0);
            if (i == 1) chk("t6_ready_busy", 32'(cfg_ready), 0);
            start = (i == 3 || i == 4);
            cfg_valid = (i == 1);
            cfg_len = 8'd1;
            if (i < 7) tick();
            start = 1'b0;
            cfg_valid = 1'b0;
        end
        chk("t6_inj", 32'(inj_count), 1);
        // reset in the middle of a burst
        load_cfg(0, 5, 0, 1, 1);
        fire();
        tick();
        chk("t1_err_pre", 32'(err_ctrl), 1);
        rst_n = 1'b0;
        #1;
        chk("t1_err", 32'(err_ctrl), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_inj", 32'(inj_count), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t1_ready", 32'(cfg_ready), 1);
        fire();
        chk("t1_idle_start", 32'(busy), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
